// File: rtl/restoring_div_16_if.sv
// Start/done handshake bundle shared by the divider and its controller.
// The div_by_zero line exists only when DIV_ZERO_FLAG_EN is defined.
interface restoring_div_16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
`ifdef DIV_ZERO_FLAG_EN
    logic             div_by_zero;
`endif

`ifdef DIV_ZERO_FLAG_EN
    modport master (
        output start, A, B,
        input  quotient, remainder, busy, done, div_by_zero
    );
    modport slave (
        input  start, A, B,
        output quotient, remainder, busy, done, div_by_zero
    );
`else
    modport master (
        output start, A, B,
        input  quotient, remainder, busy, done
    );
    modport slave (
        input  start, A, B,
        output quotient, remainder, busy, done
    );
`endif
endinterface

// File: rtl/restoring_div_16.sv
// Sequential signed restoring divider: one quotient bit per clock on operand
// magnitudes, then a sign fix. Optional flag output under DIV_ZERO_FLAG_EN.
module restoring_div_16 #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    restoring_div_16_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
`ifdef DIV_ZERO_FLAG_EN
    logic             dbz_q, dbz_d;
`endif

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;
    logic             ge;

    // The dividend register doubles as the quotient register: each iteration
    // shifts a dividend bit out of its top and a quotient bit into its bottom.
    always_comb begin
        a_mag   = bus.A[WIDTH-1] ? -bus.A : bus.A;
        b_mag   = bus.B[WIDTH-1] ? -bus.B : bus.B;
        shifted = {rem_q, dvd_q[WIDTH-1]};
        diff    = shifted[WIDTH:0] - {1'b0, dvs_q};
        ge      = (shifted >= {2'b00, dvs_q});

        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
        dbz_d     = dbz_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    neg_quo_d = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                    neg_rem_d = bus.A[WIDTH-1];
                    dvd_d     = a_mag;
                    dvs_d     = b_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    zero_d    = (bus.B == '0);
`ifdef DIV_ZERO_FLAG_EN
                    dbz_d     = 1'b0;
`endif
                    state_d   = (bus.B == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                rem_d = ge ? diff : shifted[WIDTH:0];
                dvd_d = {dvd_q[WIDTH-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // A zero divisor spends one extra cycle here so its latency
                // is a fixed two edges from accept.
                if (zero_q && (cnt_q == '0)) begin
                    cnt_d = 1'b1;
                end else begin
                    if (zero_q) begin
                        quo_d = '1;
                        rmd_d = neg_rem_q ? -dvd_q : dvd_q;
                    end else begin
                        quo_d = neg_quo_q ? -dvd_q : dvd_q;
                        rmd_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    end
                    done_d  = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                    dbz_d   = zero_q;
`endif
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rmd_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            dbz_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
`ifdef DIV_ZERO_FLAG_EN
            dbz_q     <= dbz_d;
`endif
        end
    end

    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.done        = done_q;
    assign bus.busy        = (state_q != IDLE);
`ifdef DIV_ZERO_FLAG_EN
    assign bus.div_by_zero = dbz_q;
`endif

endmodule

// File: doc/restoring_div_16.md
Name: restoring_div_16

Overview:
- Sequential signed integer divider. It is the inverse-operation companion to the team's shift-and-add / Karatsuba multipliers.
- Computes one quotient bit per clock using a restoring shift-subtract loop on operand magnitudes, then applies a sign fix.
- Sits next to the multiplier in the CPU datapath and uses the same start/done handshake, so the ALU control FSM can drive both the same way.

Parameters:
- WIDTH, 16, operand/result width in bits. Two's-complement signed. Must be >= 4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- A  input  WIDTH  signed dividend; latched on accept.
- B  input  WIDTH  signed divisor; latched on accept.
- quotient  output  WIDTH  signed quotient, registered.
- remainder  output  WIDTH  signed remainder, registered.
- busy  output  1  high while an operation is in flight (state != IDLE).
- done  output  1  one-cycle pulse; quotient/remainder are valid from this cycle.
- div_by_zero  output  1  present only with DIV_ZERO_FLAG_EN (see Optional Feature).

Behaviour:
- Reset: applies at a clk edge with reset=1 and aborts any operation in flight. Afterwards:
  - quotient=0, remainder=0, done=0, busy=0, div_by_zero=0.
  - state=IDLE, internal counter=0.
- States: IDLE, CALC, FIX.
- Accept: at edge N, state=IDLE and start=1.
  - Latch sign_q = A[MSB]^B[MSB] and sign_r = A[MSB].
  - Latch |A| and |B| as WIDTH-bit unsigned values (|-2^(WIDTH-1)| = 2^(WIDTH-1) is representable).
  - Clear the (WIDTH+1)-bit partial remainder. Set counter=0, done<=0, state<=CALC.
- Divide by zero: if B==0 at accept, skip CALC and go straight to FIX.
- CALC (one iteration per edge):
  - Shift {partial remainder, dividend} left by 1.
  - Trial subtract |B|. If the result is non-negative, keep it and set quotient bit 1; otherwise restore and set quotient bit 0.
  - counter increments. After the WIDTH-th iteration, state<=FIX.
- FIX (one edge): write registered outputs, then done<=1 for exactly one cycle, state<=IDLE.
  - quotient = sign_q ? -q_mag : q_mag
  - remainder = sign_r ? -r_mag : r_mag
  - Rounding is truncation toward zero; the remainder takes the sign of the dividend; A == quotient*B + remainder.
- Latency, normal case: start accepted at edge N -> done high in the cycle after edge N+WIDTH+1 (17 edges for WIDTH=16).
- Latency, B==0: done high after edge N+2.
- B==0 result: quotient = all ones (-1), remainder = A.
- Overflow: A=-2^(WIDTH-1), B=-1 -> quotient wraps to -2^(WIDTH-1) (0x8000), remainder 0. No flag.
- start while busy: ignored. Operands are not relatched and the operation in flight is unaffected.
- start held high continuously: a new operation is accepted on the first edge after returning to IDLE, i.e. the edge on which done is observed high.
- Output hold: quotient and remainder keep their last values until the next FIX or reset. done is low in all cycles except the single pulse.
- busy is high from the edge after accept through the FIX cycle, and low in the done cycle.

Optional Feature:
- Macro: DIV_ZERO_FLAG_EN.
- Defined:
  - Port div_by_zero exists and is registered.
  - Set to 1 together with done for a B==0 operation; otherwise set to 0 at each done.
  - Cleared on reset and on accept.
- Undefined:
  - Port is absent.
  - B==0 behaviour is otherwise identical (quotient=-1, remainder=A, same short latency).

Test Plan:
- A=100, B=7, start pulsed 1 cycle -> done 17 edges later; quotient=14, remainder=2; busy high for 17 cycles.
- A=-100, B=7 -> quotient=0xFFF2 (-14), remainder=0xFFFE (-2).
- A=100, B=-7 -> quotient=-14, remainder=2. Then A=-100, B=-7 -> quotient=14, remainder=0xFFFE (-2).
- A=1234, B=0 -> done after edge N+2; quotient=0xFFFF, remainder=1234; div_by_zero=1 when DIV_ZERO_FLAG_EN is defined.
- A=0x8000, B=0xFFFF -> quotient=0x8000, remainder=0. Also A=0x8000, B=1 -> quotient=0x8000, remainder=0.
- Start A=500, B=3, then pulse start with A=9, B=9 at cycle 4 -> ignored; result quotient=166, remainder=2. Repeat and assert reset at cycle 5 -> next edge busy=0, done=0, quotient=0, remainder=0, and no done pulse follows.
